// File: rtl/age_iq_select_pkg.sv
// Shared defaults and sizing helper for the age-ordered issue queue.
package age_iq_select_pkg;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TAG_WIDTH  = 6;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/age_iq_select_if.sv
// Enqueue / wakeup / issue bundle of the issue queue.
interface age_iq_select_if
  import age_iq_select_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
);
  localparam int OCC_W = occ_width(DEPTH);

  logic                  enq_valid;
  logic [DATA_WIDTH-1:0] enq_data;
  logic [TAG_WIDTH-1:0]  enq_tag;
  logic                  enq_tag_ready;
  logic                  enq_ready;
  logic                  wakeup_valid;
  logic [TAG_WIDTH-1:0]  wakeup_tag;
  logic                  issue_valid;
  logic [DATA_WIDTH-1:0] issue_data;
  logic                  issue_ready;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output enq_valid, enq_data, enq_tag, enq_tag_ready, wakeup_valid, wakeup_tag, issue_ready,
    input  enq_ready, issue_valid, issue_data, occupancy
  );

  modport slave (
    input  enq_valid, enq_data, enq_tag, enq_tag_ready, wakeup_valid, wakeup_tag, issue_ready,
    output enq_ready, issue_valid, issue_data, occupancy
  );
endinterface

// File: rtl/age_iq_select_pq_lsb.sv
// Lowest-index priority pick: one-hot grant plus a mask of the grant slot and everything above it.
module pq_lsb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] ack_one_hot,
  output logic [WIDTH-1:0] ack_mask
);
  // Isolate lowest set bit; mask is all-zero when nothing is requested.
  always_comb begin
    ack_one_hot = req & (~req + WIDTH'(1));
    ack_mask    = ~(ack_one_hot - WIDTH'(1));
  end
endmodule

// File: rtl/age_iq_select.sv
// Compacted, age-ordered issue queue: slot 0 oldest, oldest ready entry issues,
// younger entries collapse down over the issued slot in the same cycle.
module age_iq_select
  import age_iq_select_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
  input  logic           CLK,
  input  logic           nRST,
  age_iq_select_if.slave io
);
  localparam int OCC_W = occ_width(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                q     [DEPTH];
  entry_t                q_nxt [DEPTH];
  entry_t                woke  [DEPTH+1];  // extra top element feeds an empty entry into the last slot
  logic [OCC_W-1:0]      occ, occ_nxt, wr_idx;
  logic [DEPTH-1:0]      req_vec, ack_one_hot, ack_mask;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  full, enq_fire, issue_fire, enq_rdy_now;

  pq_lsb #(.WIDTH(DEPTH)) u_sel (
    .req         (req_vec),
    .ack_one_hot (ack_one_hot),
    .ack_mask    (ack_mask)
  );

  // Select side: purely from registered state, no wakeup bypass.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req_vec[i] = q[i].valid & q[i].ready;
      if (ack_one_hot[i]) sel_data = sel_data | q[i].data;
    end
  end

  assign full           = (occ == OCC_W'(DEPTH));
  assign io.enq_ready   = ~full;
  assign io.issue_valid = |req_vec;
  assign io.issue_data  = sel_data;
  assign io.occupancy   = occ;
  assign enq_fire       = io.enq_valid & ~full;
  assign issue_fire     = io.issue_valid & io.issue_ready;
  assign wr_idx         = occ - OCC_W'(issue_fire);
  assign occ_nxt        = occ + OCC_W'(enq_fire) - OCC_W'(issue_fire);
  assign enq_rdy_now    = io.enq_tag_ready | (io.wakeup_valid & (io.enq_tag == io.wakeup_tag));

  // Wakeup on pre-shift slots, then collapse over the issued slot, then drop in the new entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]       = q[i];
      woke[i].ready = q[i].ready |
                      (q[i].valid & io.wakeup_valid & (q[i].tag == io.wakeup_tag));
    end
    woke[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = (issue_fire && ack_mask[i]) ? woke[i+1] : woke[i];
      if (enq_fire && (wr_idx == OCC_W'(i))) begin
        q_nxt[i].valid = 1'b1;
        q_nxt[i].ready = enq_rdy_now;
        q_nxt[i].tag   = io.enq_tag;
        q_nxt[i].data  = io.enq_data;
      end
    end
  end

  // Entry array and occupancy; reset drops every entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      occ <= occ_nxt;
    end
  end
endmodule

// File: tb/tb_age_iq_select.sv
// Directed bench for age_iq_select (DEPTH=4): scoreboard of expected issue payloads
// checked on every issue handshake, plus direct state checks between steps.
module tb_age_iq_select;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int TW    = 4;

  logic clk = 1'b0;
  logic nrst;
  int   tests  = 0;
  int   failed = 0;
  logic [DW-1:0] sb [$];

  age_iq_select_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  age_iq_select #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .io   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after posedge; sample here, mid-cycle.
  always @(negedge clk) begin
    if (nrst && bus.issue_valid && bus.issue_ready) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $error("FAIL sb_unexpected_issue: observed %0h expected none", bus.issue_data);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        tests++;
        assert (bus.issue_data === e) else begin
          failed++;
          $error("FAIL sb_issue_data: observed %0h expected %0h", bus.issue_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enq_valid     = 1'b0;
    bus.enq_data      = '0;
    bus.enq_tag       = '0;
    bus.enq_tag_ready = 1'b0;
    bus.wakeup_valid  = 1'b0;
    bus.wakeup_tag    = '0;
    bus.issue_ready   = 1'b0;
  endtask

  task automatic enq(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic rdy);
    bus.enq_valid     = 1'b1;
    bus.enq_data      = d;
    bus.enq_tag       = t;
    bus.enq_tag_ready = rdy;
    step();
    bus.enq_valid     = 1'b0;
    bus.enq_tag_ready = 1'b0;
  endtask

  task automatic wake(input logic [TW-1:0] t);
    bus.wakeup_valid = 1'b1;
    bus.wakeup_tag   = t;
    step();
    bus.wakeup_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.issue_ready = 1'b1;
    repeat (n) step();
    bus.issue_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    nrst = 1'b0;
    #12;
    nrst = 1'b1;
    step();

    // Reset with traffic pending
    enq(8'hE1, 4'd1, 1'b1);
    enq(8'hE2, 4'd2, 1'b0);
    check("pre_reset_occ", 32'(bus.occupancy), 32'd2);
    bus.enq_valid    = 1'b1;
    bus.enq_data     = 8'hE3;
    bus.wakeup_valid = 1'b1;
    bus.wakeup_tag   = 4'd2;
    #2 nrst = 1'b0;
    #1;
    check("rst_occ",         32'(bus.occupancy),   32'd0);
    check("rst_enq_ready",   32'(bus.enq_ready),   32'd1);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_issue_data",  32'(bus.issue_data),  32'd0);
    idle_inputs();
    step();
    nrst = 1'b1;
    step();
    check("post_rst_occ", 32'(bus.occupancy), 32'd0);

    // Fill and ordering
    enq(8'hA1, 4'd1, 1'b1);
    enq(8'hB2, 4'd2, 1'b1);
    enq(8'hC3, 4'd3, 1'b1);
    enq(8'hD4, 4'd4, 1'b1);
    check("fill_occ",       32'(bus.occupancy),  32'd4);
    check("fill_enq_ready", 32'(bus.enq_ready),  32'd0);
    check("fill_head",      32'(bus.issue_data), 32'hA1);
    sb.push_back(8'hA1); sb.push_back(8'hB2); sb.push_back(8'hC3); sb.push_back(8'hD4);
    drain(4);
    check("fill_drained_occ",   32'(bus.occupancy),   32'd0);
    check("fill_drained_valid", 32'(bus.issue_valid), 32'd0);

    // Out-of-order wakeup
    enq(8'h11, 4'd3, 1'b0);
    enq(8'h22, 4'd5, 1'b0);
    enq(8'h33, 4'd7, 1'b0);
    check("ooo_none_ready", 32'(bus.issue_valid), 32'd0);
    wake(4'd5);
    check("ooo_valid", 32'(bus.issue_valid), 32'd1);
    check("ooo_data",  32'(bus.issue_data),  32'h22);
    sb.push_back(8'h22);
    drain(1);
    check("ooo_occ", 32'(bus.occupancy), 32'd2);
    wake(4'd7);
    check("ooo_33_alone", 32'(bus.issue_data), 32'h33);
    wake(4'd3);
    check("ooo_older_displaces", 32'(bus.issue_data), 32'h11);
    sb.push_back(8'h11); sb.push_back(8'h33);
    drain(2);
    check("ooo_empty", 32'(bus.occupancy), 32'd0);

    // Full with simultaneous issue
    enq(8'h41, 4'd1, 1'b0);
    enq(8'h42, 4'd2, 1'b0);
    enq(8'h43, 4'd3, 1'b1);
    enq(8'h44, 4'd4, 1'b0);
    check("full_occ",       32'(bus.occupancy),  32'd4);
    check("full_enq_ready", 32'(bus.enq_ready),  32'd0);
    check("full_sel_slot2", 32'(bus.issue_data), 32'h43);
    sb.push_back(8'h43);
    bus.enq_valid     = 1'b1;
    bus.enq_data      = 8'h99;
    bus.enq_tag       = 4'd9;
    bus.enq_tag_ready = 1'b1;
    bus.issue_ready   = 1'b1;
    step();
    idle_inputs();
    check("full_issue_occ",  32'(bus.occupancy), 32'd3);
    check("full_enq_reopen", 32'(bus.enq_ready), 32'd1);
    wake(4'd1);
    wake(4'd2);
    wake(4'd4);
    check("full_head_after", 32'(bus.issue_data), 32'h41);
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h44);
    drain(3);
    check("full_rejected_not_stored", 32'(bus.issue_valid), 32'd0);
    check("full_empty", 32'(bus.occupancy), 32'd0);

    // Enqueue with same-cycle wakeup
    bus.wakeup_valid = 1'b1;
    bus.wakeup_tag   = 4'd9;
    enq(8'h5A, 4'd9, 1'b0);
    bus.wakeup_valid = 1'b0;
    check("enq_wake_valid", 32'(bus.issue_valid), 32'd1);
    check("enq_wake_data",  32'(bus.issue_data),  32'h5A);
    sb.push_back(8'h5A);
    drain(1);

    // Mid-shift wakeup
    enq(8'h10, 4'd1, 1'b1);
    enq(8'h20, 4'd2, 1'b0);
    enq(8'h30, 4'd6, 1'b0);
    sb.push_back(8'h10);
    bus.issue_ready  = 1'b1;
    bus.wakeup_valid = 1'b1;
    bus.wakeup_tag   = 4'd6;
    step();
    idle_inputs();
    check("shift_occ",   32'(bus.occupancy),   32'd2);
    check("shift_valid", 32'(bus.issue_valid), 32'd1);
    check("shift_data",  32'(bus.issue_data),  32'h30);
    sb.push_back(8'h30);
    drain(1);
    check("shift_20_waits", 32'(bus.issue_valid), 32'd0);
    wake(4'd2);
    sb.push_back(8'h20);
    drain(1);
    check("shift_empty", 32'(bus.occupancy), 32'd0);

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/age_iq_select.md
Name: age_iq_select

Overview:
- Small age-ordered issue queue that consumes the one-hot grant and mask produced by pq_lsb.
- Entries are kept compacted, with entry 0 the oldest.
- Each entry waits on one tag. A tag broadcast marks the entry ready.
- The oldest ready entry is selected through pq_lsb and issued over a valid/ready handshake. Entries above the issued slot shift down one position in the same cycle.

Parameters:
- DEPTH, 8: number of entries; power of two not required, minimum 2.
- DATA_WIDTH, 32: payload width per entry.
- TAG_WIDTH, 6: width of the wait tag and the wakeup tag.

Ports:
- CLK  input  1  clock; all state changes on the posedge.
- nRST  input  1  reset; asynchronous, active-low.
- enq_valid  input  1  enqueue request.
- enq_data  input  DATA_WIDTH  enqueue payload.
- enq_tag  input  TAG_WIDTH  tag this entry waits on.
- enq_tag_ready  input  1  entry is already ready at enqueue.
- enq_ready  output  1  queue can accept; equals !full.
- wakeup_valid  input  1  tag broadcast valid.
- wakeup_tag  input  TAG_WIDTH  broadcast tag.
- issue_valid  output  1  some entry is valid and ready.
- issue_data  output  DATA_WIDTH  payload of the oldest valid and ready entry.
- issue_ready  input  1  downstream accepts the issue.
- occupancy  output  $clog2(DEPTH+1)  count of valid entries.

Behaviour:
- State per entry: valid, ready, tag, data. Valid entries always occupy slots 0..occupancy-1.
- Reset (async, nRST=0): all valid and ready bits cleared, occupancy=0, enq_ready=1, issue_valid=0, issue_data=0. Tag and data need no reset. Reset mid-operation drops every entry immediately.
- Select (combinational from registered state):
  - req_vec = valid & ready, driven into the pq_lsb instance.
  - issue_valid = |req_vec.
  - issue_data = OR over entries of (ack_one_hot[i] ? data[i] : 0), so it is 0 when nothing is selected.
- Issue fire = issue_valid & issue_ready. On fire, slot s (ack_one_hot) is removed. Every slot i >= s with ack_mask[i] set loads slot i+1 (and its valid/ready/tag). The top slot loads invalid.
- Enqueue fire = enq_valid & enq_ready.
  - enq_ready depends only on registered occupancy (full = occupancy==DEPTH). A full queue rejects enqueue even when an issue fires the same cycle.
  - The new entry is written at slot occupancy, or occupancy-1 when an issue fires the same cycle.
- Occupancy next = occupancy + enq fire - issue fire. Simultaneous enqueue and issue leaves occupancy unchanged.
- Wakeup:
  - When wakeup_valid is high, each valid entry with tag==wakeup_tag sets ready. This is evaluated on the pre-shift slot and carried with the entry if it shifts.
  - An entry enqueued in the same cycle becomes ready if enq_tag_ready is set, or if wakeup_valid is high and enq_tag==wakeup_tag.
  - Ready is sticky until the entry is issued.
- Latency: an entry enqueued ready at cycle t can issue at t+1. A wakeup at cycle t enables issue at t+1. No same-cycle wakeup-to-issue bypass.
- A held issue (issue_ready=0) keeps issue_valid and issue_data stable. A newly readied older entry may displace the current selection; oldest-first priority always holds.
- No overflow or underflow is possible: enqueue is gated by enq_ready, issue by issue_valid. Inputs outside a fire are ignored.

Decomposition:
- Instantiate one pq_lsb #(.WIDTH(DEPTH)) for the select.
- The entry struct is parameterised, so it is defined locally in the module, not in core_types_pkg.
- No new shared constants are needed.

Test Plan (DEPTH=4, DATA_WIDTH=8, TAG_WIDTH=4):
- Reset with traffic pending: drive nRST=0 while enqueue and wakeup are active -> occupancy=0, enq_ready=1, issue_valid=0, issue_data=0 immediately, without waiting for CLK.
- Fill and ordering:
  - Enqueue A1,B2,C3,D4, all enq_tag_ready=1, issue_ready=0 -> occupancy=4, enq_ready=0.
  - Set issue_ready=1 -> issue_data sequence A1,B2,C3,D4 on consecutive cycles.
- Out-of-order wakeup:
  - Enqueue entries 0x11 tag 3, 0x22 tag 5, 0x33 tag 7, all not ready.
  - Wakeup tag 5 -> next cycle issue_valid=1, issue_data=0x22.
  - After issue, entry 0x33 sits in slot 1 and occupancy=2.
- Full with simultaneous issue: occupancy=4 with slot 2 ready, enq_valid=1, issue_ready=1 -> enqueue rejected (enq_ready=0), issue fires, occupancy=3; next cycle enq_ready=1.
- Enqueue with same-cycle wakeup: enqueue 0x5A tag 9 with wakeup_valid=1, wakeup_tag=9 -> next cycle issue_valid=1, issue_data=0x5A.
- Mid-shift wakeup:
  - Slots 0x10 (ready), 0x20 tag 2, 0x30 tag 6.
  - Issue slot 0 and wakeup tag 6 in the same cycle -> next cycle 0x30 sits in slot 1 and is ready; issue_data=0x30.
